// File: rtl/spi_master.sv
// SPI mode-0 master: sends one byte LSB-first on MOSI while capturing one byte from MISO.
// Optional back-to-back transfers with CS_N held low: define SPI_MST_BURST_EN.
module spi_master #(
   parameter int FPGA_CLK = 12_000_000,
   parameter int SPI_CLK  = 1_000_000,
   parameter int HALF     = FPGA_CLK / (2 * SPI_CLK)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF - 1);

   if (HALF < 1) begin : g_bad_half
      $error("spi_master: HALF must be >= 1 (FPGA_CLK >= 2*SPI_CLK)");
   end

`ifdef SPI_MST_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] div;
   logic [2:0]       bit_cnt;
   logic [7:0]       tx_sh;
   logic [7:0]       rx_sh;
   logic             tick;
   logic             last;
   logic             hs;

   // last = the falling edge closing bit 7; this is also the rx_valid cycle
   always_comb begin
      tick     = (div == DIV_MAX);
      last     = (state == SHIFT) && tick && sclk && (bit_cnt == 3'd7);
      tx_ready = (state == IDLE) || (BURST && last);
      hs       = tx_valid && tx_ready;
      state_nx = state;
      case (state)
         IDLE:    if (hs)   state_nx = SETUP;
         SETUP:   if (tick) state_nx = SHIFT;
         SHIFT:   if (last) state_nx = hs ? SHIFT : HOLD;
         HOLD:    if (tick) state_nx = GAP;
         GAP:     if (tick) state_nx = IDLE;
         default:           state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div      <= '0;
         bit_cnt  <= 3'd0;
         tx_sh    <= 8'h00;
         rx_sh    <= 8'h00;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         if (state == IDLE || tick) div <= '0;
         else                       div <= div + DIV_W'(1);
         case (state)
            IDLE: begin
               if (hs) begin
                  tx_sh   <= tx_data;
                  mosi    <= tx_data[0];
                  cs_n    <= 1'b0;
                  bit_cnt <= 3'd0;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!sclk) begin
                     sclk           <= 1'b1;
                     rx_sh[bit_cnt] <= miso;
                  end else begin
                     sclk    <= 1'b0;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        // burst: reload and start the next byte with no SETUP
                        if (hs) begin
                           tx_sh <= tx_data;
                           mosi  <= tx_data[0];
                        end
                     end else begin
                        mosi <= tx_sh[bit_cnt + 3'd1];
                     end
                  end
               end
            end
            HOLD: if (tick) cs_n <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard of expected rx bytes, loopback/slave/tied-high MISO,
// reset abort, busy-ignore and a HALF=1 instance.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, rx_valid, sclk, mosi, miso, cs_n;
   logic [7:0] rx_data;

   logic       tx_valid1 = 1'b0;
   logic [7:0] tx_data1 = 8'h00;
   logic       tx_ready1, rx_valid1, sclk1, mosi1, cs_n1;
   logic [7:0] rx_data1;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [1:0] mode = 2'd0;
   logic [7:0] slv_byte = 8'h3C;
   logic [7:0] sb[$];
   int         rise_cyc_q[$];
   logic       mosi_q[$];

   int   n_rise = 0, rx_cnt = 0, rxv_cyc = 0, hi_cnt = 0, cs_hi_len = 0;
   int   cs_fall_cyc = 0, cs_fall_prev = 0, cs_low_len = 0, cs_rises = 0;
   logic sclk_p = 1'b0, cs_p = 1'b1;
   int   tg1 = 0, tg1_first = 0, tg1_last = 0, rx1_cnt = 0;
   logic sclk1_p = 1'b0, cs1_p = 1'b1;
   logic [7:0] rx1_seen = 8'h00;

   assign miso = (mode == 2'd0) ? mosi : (mode == 2'd1) ? slv_byte[n_rise[2:0]] : 1'b1;

   spi_master u_dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   spi_master #(.FPGA_CLK(2_000_000), .SPI_CLK(1_000_000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
      .rx_valid(rx_valid1), .rx_data(rx_data1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1),
      .cs_n(cs_n1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // main-instance monitor: edges, cs_n timing, scoreboard pops
   always @(negedge clk) begin
      if (sclk && !sclk_p) begin
         rise_cyc_q.push_back(cyc);
         mosi_q.push_back(mosi);
         n_rise++;
      end
      sclk_p = sclk;
      if (!cs_n && cs_p) begin
         cs_fall_prev = cs_fall_cyc;
         cs_fall_cyc  = cyc;
         cs_hi_len    = hi_cnt;
      end
      if (cs_n && !cs_p) begin
         cs_low_len = cyc - cs_fall_cyc;
         cs_rises++;
      end
      hi_cnt = cs_n ? hi_cnt + 1 : 0;
      if (cs_n) n_rise = 0;
      cs_p = cs_n;
      if (rx_valid) begin
         rx_cnt++;
         rxv_cyc = cyc;
         if (sb.size() == 0) check("rx_unexpected_queue", sb.size(), 1);
         else                check("rx_data", rx_data, sb.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!cs_n1 && cs1_p) tg1 = 0;
      if (!cs_n1 && sclk1 != sclk1_p) begin
         if (tg1 == 0) tg1_first = cyc;
         tg1_last = cyc;
         tg1++;
      end
      sclk1_p = sclk1;
      cs1_p   = cs_n1;
      if (rx_valid1) begin
         rx1_cnt++;
         rx1_seen = rx_data1;
      end
   end

   task automatic send(input logic [7:0] b, input logic [7:0] exp);
      int k = 0;
      @(negedge clk);
      while (!tx_ready && k < 300) begin @(negedge clk); k++; end
      check("send_ready", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = b;
      sb.push_back(exp);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input int target, input string tag);
      int k = 0;
      while (rx_cnt < target && k < 1000) begin @(negedge clk); #1; k++; end
      check(tag, rx_cnt, target);
      k = 0;
      while (!tx_ready && k < 100) begin @(negedge clk); #1; k++; end
   endtask

   initial begin
      int   r0, c0, k;
      logic [7:0] mb;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_tx_ready", tx_ready, 1);
      rst_n = 1'b1;

      // 1: loopback 0xA5
      mode = 2'd0;
      r0 = rx_cnt;
      send(8'hA5, 8'hA5);
      wait_rx(r0 + 1, "t1_rx_count");
      check("t1_cs_low_len", cs_low_len, 108);
      check("t1_rxv_latency", rxv_cyc - cs_fall_cyc, 102);

      // 2: slave returns 0x3C, master sends 0xC3
      mode = 2'd1;
      slv_byte = 8'h3C;
      mosi_q.delete();
      rise_cyc_q.delete();
      r0 = rx_cnt;
      send(8'hC3, 8'h3C);
      wait_rx(r0 + 1, "t2_rx_count");
      check("t2_rise_count", mosi_q.size(), 8);
      mb = 8'h00;
      for (int i = 0; i < 8 && i < mosi_q.size(); i++) mb[i] = mosi_q[i];
      check("t2_mosi_bits", mb, 8'hC3);
      if (rise_cyc_q.size() >= 2) check("t2_sclk_period", rise_cyc_q[1] - rise_cyc_q[0], 12);
      else                        check("t2_sclk_rises", rise_cyc_q.size(), 2);

      // 3: miso high, tx_valid held across two bytes
      mode = 2'd2;
      r0 = rx_cnt;
      c0 = cs_rises;
      @(negedge clk);
      k = 0;
      while (!tx_ready && k < 300) begin @(negedge clk); k++; end
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      sb.push_back(8'hFF);
      @(posedge clk);
      #1 tx_data = 8'hFF;
      @(negedge clk);
      k = 0;
      while (!tx_ready && k < 300) begin @(negedge clk); k++; end
      check("t3_second_ready", tx_ready, 1);
      sb.push_back(8'hFF);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      wait_rx(r0 + 2, "t3_rx_count");
`ifdef SPI_MST_BURST_EN
      check("t3_cs_rises_burst", cs_rises - c0, 1);
`else
      check("t3_cs_rises", cs_rises - c0, 2);
      check("t3_gap_ge6", cs_hi_len >= 6, 1);
      check("t3_hs_to_hs", cs_fall_cyc - cs_fall_prev, 115);
`endif

      // 4: reset after 3rd rising edge
      mode = 2'd0;
      send(8'h77, 8'h77);
      k = 0;
      while (n_rise < 3 && k < 300) begin @(negedge clk); #1; k++; end
      check("t4_third_rise", n_rise, 3);
      r0 = rx_cnt;
      rst_n = 1'b0;
      #1;
      check("t4_rst_cs_n", cs_n, 1);
      check("t4_rst_sclk", sclk, 0);
      check("t4_rst_tx_ready", tx_ready, 1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      check("t4_no_rx_valid", rx_cnt, r0);
      send(8'h5A, 8'h5A);
      wait_rx(r0 + 1, "t4_rx_after_reset");

      // 5: tx_valid pulse while busy is ignored
      r0 = rx_cnt;
      send(8'h66, 8'h66);
      repeat (30) @(negedge clk);
      check("t5_busy_ready", tx_ready, 0);
      tx_valid = 1'b1;
      tx_data  = 8'h11;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      wait_rx(r0 + 1, "t5_rx_count");
      repeat (20) @(negedge clk);
      check("t5_single_pulse", rx_cnt, r0 + 1);

      // 6: HALF=1 instance, loopback 0x96
      @(negedge clk);
      k = 0;
      while (!tx_ready1 && k < 100) begin @(negedge clk); k++; end
      check("t6_ready", tx_ready1, 1);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h96;
      @(posedge clk);
      #1 tx_valid1 = 1'b0;
      k = 0;
      while (rx1_cnt < 1 && k < 100) begin @(negedge clk); #1; k++; end
      check("t6_rx_count", rx1_cnt, 1);
      check("t6_rx_data", rx1_seen, 8'h96);
      repeat (10) @(negedge clk);
      check("t6_sclk_toggles", tg1, 16);
      check("t6_toggle_span", tg1_last - tg1_first, 15);

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
